// File: rtl/snake_pkg.sv
// Shared grid geometry, cell type and spawn FSM states for the snake game.
// Pure declarations: no logic, no latency.
package snake_pkg;

    localparam int GRID_W  = 14;
    localparam int GRID_H  = 14;
    localparam int MAX_SEG = 50;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_SCAN,
        ST_PLACED
    } state_t;

endpackage

// File: rtl/apple_cand_gen.sv
// Next apple candidate: folded random cell or previous candidate advanced in raster order.
// Purely combinational, zero latency, no flow control.
module apple_cand_gen #(
    parameter int GRID_W = snake_pkg::GRID_W,
    parameter int GRID_H = snake_pkg::GRID_H
) (
    input  logic              use_rand,
    input  logic [3:0]        rand_x,
    input  logic [3:0]        rand_y,
    input  snake_pkg::cell_t  prev,
    output snake_pkg::cell_t  cand
);

    localparam logic [3:0] W_LIM  = 4'(GRID_W);
    localparam logic [3:0] H_LIM  = 4'(GRID_H);
    localparam logic [3:0] W_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] H_LAST = 4'(GRID_H - 1);

    snake_pkg::cell_t folded;
    snake_pkg::cell_t advanced;

    always_comb begin
        // LFSR range is 0..15; a single subtract maps it back onto the grid
        folded.x = (rand_x >= W_LIM) ? rand_x - W_LIM : rand_x;
        folded.y = (rand_y >= H_LIM) ? rand_y - H_LIM : rand_y;

        advanced = prev;
        if (prev.x == W_LAST) begin
            advanced.x = 4'd0;
            advanced.y = (prev.y == H_LAST) ? 4'd0 : prev.y + 4'd1;
        end else begin
            advanced.x = prev.x + 4'd1;
        end

        cand = use_rand ? folded : advanced;
    end

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement: pick a candidate, scan the snake body, commit the first body-free cell.
// Latency 1 + max(body_len,1) cycles per candidate; eaten is only honoured while PLACED.
module apple_spawn_ctrl #(
    parameter int GRID_W    = snake_pkg::GRID_W,
    parameter int GRID_H    = snake_pkg::GRID_H,
    parameter int MAX_SEG   = snake_pkg::MAX_SEG,
    parameter int MAX_TRIES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eaten,
    input  logic [3:0] rand_x,
    input  logic [3:0] rand_y,
    input  logic [5:0] body_len,
    output logic [5:0] body_idx,
    input  logic [7:0] body_seg,
    output logic [3:0] apple_x,
    output logic [3:0] apple_y,
    output logic       apple_valid,
    output logic       busy
);

    import snake_pkg::*;

    localparam int              TW      = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   TRY_SAT = TW'(MAX_TRIES);
    localparam logic [5:0]      SEG_MAX = 6'(MAX_SEG);

    state_t         state, state_nxt;
    cell_t          cand, cand_nxt, gen_cand;
    logic [TW-1:0]  tries, tries_nxt;
    logic [5:0]     idx_nxt;
    logic [5:0]     eff_len;
    logic [3:0]     ax_nxt, ay_nxt;
    logic           av_nxt;
    logic           use_rand;

    assign eff_len  = (body_len > SEG_MAX) ? SEG_MAX : body_len;
    assign busy     = (state == ST_CAND) || (state == ST_SCAN);
    assign use_rand = (tries < TRY_SAT);

    apple_cand_gen #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_cand_gen (
        .use_rand (use_rand),
        .rand_x   (rand_x),
        .rand_y   (rand_y),
        .prev     (cand),
        .cand     (gen_cand)
    );

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        tries_nxt = tries;
        idx_nxt   = body_idx;
        ax_nxt    = apple_x;
        ay_nxt    = apple_y;
        av_nxt    = apple_valid;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_CAND;
            end
            ST_CAND: begin
                cand_nxt  = gen_cand;
                idx_nxt   = 6'd0;
                state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if ((eff_len != 6'd0) && (body_seg == cand)) begin
                    tries_nxt = (tries == TRY_SAT) ? tries : tries + TW'(1);
                    idx_nxt   = 6'd0;
                    state_nxt = ST_CAND;
                end else if ((eff_len == 6'd0) || (body_idx == eff_len - 6'd1)) begin
                    ax_nxt    = cand.x;
                    ay_nxt    = cand.y;
                    av_nxt    = 1'b1;
                    tries_nxt = '0;
                    idx_nxt   = 6'd0;
                    state_nxt = ST_PLACED;
                end else begin
                    idx_nxt = body_idx + 6'd1;
                end
            end
            ST_PLACED: begin
                // old coordinates stay visible until the next commit
                if (eaten) begin
                    av_nxt    = 1'b0;
                    state_nxt = ST_CAND;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cand        <= '0;
            tries       <= '0;
            body_idx    <= 6'd0;
            apple_x     <= 4'd0;
            apple_y     <= 4'd0;
            apple_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            tries       <= tries_nxt;
            body_idx    <= idx_nxt;
            apple_x     <= ax_nxt;
            apple_y     <= ay_nxt;
            apple_valid <= av_nxt;
        end
    end

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: directed and random spawns, reference model feeds a scoreboard queue.
module tb_apple_spawn_ctrl;
    import snake_pkg::*;

    localparam int MAX_TRIES = 4;

    logic       clk = 1'b0;
    logic       reset, eaten;
    logic [3:0] rand_x, rand_y;
    logic [5:0] body_len;
    logic [5:0] body_idx;
    logic [7:0] body_seg;
    logic [3:0] apple_x, apple_y;
    logic       apple_valid, busy;

    logic [7:0] tb_body [64];
    int         blen;

    typedef struct {
        cell_t c;
        int    due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rise = -1;
    int   launch_cyc = 0;
    bit   prev_av = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign body_len = 6'(blen);
    assign body_seg = tb_body[body_idx];

    apple_spawn_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .eaten       (eaten),
        .rand_x      (rand_x),
        .rand_y      (rand_y),
        .body_len    (body_len),
        .body_idx    (body_idx),
        .body_seg    (body_seg),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .busy        (busy)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic cell_t mk(input int x, input int y);
        cell_t c;
        c.x = 4'(x);
        c.y = 4'(y);
        return c;
    endfunction

    function automatic cell_t tb_fold(input cell_t r);
        int x, y;
        x = int'(r.x);
        y = int'(r.y);
        if (x >= GRID_W) x = x - GRID_W;
        if (y >= GRID_H) y = y - GRID_H;
        return mk(x, y);
    endfunction

    // Reference: walk the candidate sequence with raster-index arithmetic and count cycles per candidate.
    function automatic void model(input cell_t r0, input cell_t r1, output cell_t res, output int lat);
        int    eff, px, py, cx, cy, hit, lin;
        cell_t rr;
        eff = (blen > MAX_SEG) ? MAX_SEG : blen;
        px = 0; py = 0; lat = 0; res = '0;
        for (int t = 0; t < 4000; t++) begin
            if (t < MAX_TRIES) begin
                rr = tb_fold((t == 0) ? r0 : r1);
                cx = int'(rr.x);
                cy = int'(rr.y);
            end else begin
                lin = (py * GRID_W + px + 1) % (GRID_W * GRID_H);
                cx = lin % GRID_W;
                cy = lin / GRID_W;
            end
            px = cx; py = cy;
            hit = -1;
            for (int i = 0; i < eff; i++)
                if (hit < 0 && tb_body[i] == {4'(cx), 4'(cy)}) hit = i;
            if (hit < 0) begin
                lat = lat + 1 + ((eff == 0) ? 1 : eff);
                res = mk(cx, cy);
                return;
            end
            lat = lat + 2 + hit;
        end
    endfunction

    task automatic finish_up();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Starts a spawn either by releasing reset or by an eaten pulse; r1 feeds every retry after the first.
    task automatic launch(input bit via_reset, input cell_t r0, input cell_t r1);
        cell_t res;
        int    lat;
        exp_t  e;
        model(r0, r1, res, lat);
        rand_x = r0.x;
        rand_y = r0.y;
        launch_cyc = cyc;
        e.c = res;
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        if (via_reset) reset = 1'b0;
        else eaten = 1'b1;
        @(posedge clk); #1;
        eaten = 1'b0;
        chk("valid_low_after_start", int'(apple_valid), 0);
        chk("busy_after_start", int'(busy), 1);
        @(posedge clk); #1;
        rand_x = r1.x;
        rand_y = r1.y;
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        while (!apple_valid && n < 12000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!apple_valid) begin
            checks++;
            failures++;
            $display("FAIL commit_timeout: apple_valid still 0 after %0d cycles", n);
            finish_up();
        end
        @(negedge clk); #1;
    endtask

    task automatic chk_apple(input string name, input int x, input int y);
        chk({name, "_x"}, int'(apple_x), x);
        chk({name, "_y"}, int'(apple_y), y);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, int'(apple_valid), 0);
        chk({name, "_x"}, int'(apple_x), 0);
        chk({name, "_y"}, int'(apple_y), 0);
        chk({name, "_idx"}, int'(body_idx), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic fill_rows(input int n);
        for (int i = 0; i < 64; i++) tb_body[i] = {4'(i % GRID_W), 4'(1 + (i / GRID_W) % 4)};
        blen = n;
    endtask

    // Monitor: every rising apple_valid must match the oldest expectation, on the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        if (apple_valid && !prev_av) begin
            last_rise = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit: apple (%0d,%0d) at cycle %0d with nothing expected",
                         apple_x, apple_y, cyc);
            end else begin
                e = sb.pop_front();
                chk("sb_apple_x", int'(apple_x), int'(e.c.x));
                chk("sb_apple_y", int'(apple_y), int'(e.c.y));
                chk("sb_commit_cycle", cyc, e.due);
            end
        end
        if (apple_valid && !reset) begin
            chk("placed_idx_zero", int'(body_idx), 0);
            chk("placed_not_busy", int'(busy), 0);
        end
        prev_av = apple_valid;
    end

    initial begin
        cell_t r0, r1;
        int    lim;
        reset = 1'b1; eaten = 1'b0; rand_x = 4'd0; rand_y = 4'd0; blen = 0;
        for (int i = 0; i < 64; i++) tb_body[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // four-segment body, free random cell: valid six cycles after release
        tb_body[0] = {4'd4, 4'd7}; tb_body[1] = {4'd4, 4'd6};
        tb_body[2] = {4'd4, 4'd5}; tb_body[3] = {4'd4, 4'd4};
        blen = 4;
        launch(1'b1, mk(5, 8), mk(5, 8));
        wait_commit();
        chk("release_to_valid", last_rise - launch_cyc, 6);
        chk_apple("first_spawn", 5, 8);

        tb_body[0] = {4'd0, 4'd0}; blen = 1;
        launch(1'b0, mk(15, 14), mk(15, 14));
        wait_commit();
        chk_apple("fold", 1, 0);

        tb_body[0] = {4'd1, 4'd1}; tb_body[1] = {4'd2, 4'd2};
        tb_body[2] = {4'd4, 4'd8}; tb_body[3] = {4'd3, 4'd3}; blen = 4;
        launch(1'b0, mk(4, 8), mk(9, 9));
        wait_commit();
        chk_apple("retry", 9, 9);

        tb_body[0] = {4'd4, 4'd7}; tb_body[1] = {4'd5, 4'd7}; blen = 2;
        launch(1'b0, mk(4, 7), mk(4, 7));
        wait_commit();
        chk_apple("fallback", 6, 7);

        tb_body[0] = {4'd13, 4'd13}; blen = 1;
        launch(1'b0, mk(13, 13), mk(13, 13));
        wait_commit();
        chk_apple("wrap_corner", 0, 0);

        tb_body[0] = {4'd13, 4'd2}; blen = 1;
        launch(1'b0, mk(13, 2), mk(13, 2));
        wait_commit();
        chk_apple("wrap_row", 0, 3);

        blen = 0;
        launch(1'b0, mk(3, 3), mk(3, 3));
        wait_commit();
        chk_apple("empty_body", 3, 3);

        // body_len above MAX_SEG: entries past the limit must be ignored
        fill_rows(60);
        for (int i = MAX_SEG; i < 60; i++) tb_body[i] = {4'd7, 4'd7};
        launch(1'b0, mk(7, 7), mk(7, 7));
        wait_commit();
        chk_apple("len_clamp", 7, 7);

        // eaten while scanning is dropped
        fill_rows(20);
        launch(1'b0, mk(0, 9), mk(0, 9));
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid_scan", int'(busy), 1);
        eaten = 1'b1;
        @(posedge clk); #1;
        eaten = 1'b0;
        wait_commit();
        repeat (30) @(posedge clk);
        #1;
        chk("eaten_in_scan_ignored", int'(apple_valid), 1);

        // reset during a long scan
        fill_rows(30);
        launch(1'b0, mk(0, 10), mk(0, 10));
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        eaten = 1'b1;
        @(posedge clk); #1;
        eaten = 1'b0;
        sb.delete();
        chk_reset_outputs("mid_scan_reset");
        @(posedge clk); #1;
        blen = 3;
        launch(1'b1, mk(11, 12), mk(11, 12));
        wait_commit();
        chk_apple("after_reset", 11, 12);

        for (int it = 0; it < 40; it++) begin
            blen = ($urandom_range(0, 9) == 0) ? 55 : int'($urandom_range(0, 14));
            for (int i = 0; i < 64; i++)
                tb_body[i] = {4'($urandom_range(0, GRID_W - 1)), 4'($urandom_range(0, GRID_H - 1))};
            r0 = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            r1 = ($urandom_range(0, 3) == 0) ? mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15))) : r0;
            lim = (blen > MAX_SEG) ? MAX_SEG : blen;
            if (lim > 0 && $urandom_range(0, 2) == 0) tb_body[$urandom_range(0, lim - 1)] = tb_fold(r0);
            launch(1'b0, r0, r1);
            wait_commit();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        finish_up();
    end

endmodule

// File: doc/apple_spawn_ctrl.md
APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

Interface
REQ-001 Parameter GRID_W, default 14, grid columns (x 0..GRID_W-1).
REQ-002 Parameter GRID_H, default 14, grid rows (y 0..GRID_H-1).
REQ-003 Parameter MAX_SEG, default 50, maximum snake segments.
REQ-004 Parameter MAX_TRIES, default 4, random candidates tried before linear fallback.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 eaten  in  1  one-cycle pulse: the apple was eaten (from collision logic).
REQ-008 rand_x  in  4  random column from the LFSR; values may exceed GRID_W-1.
REQ-009 rand_y  in  4  random row from the LFSR; values may exceed GRID_H-1.
REQ-010 body_len  in  6  number of valid body segments, 0..MAX_SEG.
REQ-011 body_idx  out  6  body memory read address.
REQ-012 body_seg  in  8  segment at body_idx, {x[7:4], y[3:0]}, same-cycle combinational read.
REQ-013 apple_x  out  4  committed apple column.
REQ-014 apple_y  out  4  committed apple row.
REQ-015 apple_valid  out  1  apple_x/apple_y hold a committed, body-free cell.
REQ-016 busy  out  1  high in CAND and SCAN.

Function
REQ-017 FSM states: IDLE, CAND, SCAN, PLACED.
REQ-018 IDLE -> CAND unconditionally next cycle (first spawn after reset).
REQ-019 CAND (one cycle): latch candidate, clear body_idx to 0, go to SCAN.
REQ-020 Candidate source: tries < MAX_TRIES -> folded random; otherwise previous candidate advanced linearly.
REQ-021 Fold: x = rand_x >= GRID_W ? rand_x - GRID_W : rand_x; y uses the same rule with GRID_H.
REQ-022 Linear advance: x+1; at x = GRID_W-1 wrap x to 0 and y+1; at (GRID_W-1, GRID_H-1) wrap to (0,0).
REQ-023 SCAN: each cycle compare body_seg with the candidate; on match, tries+1 (saturating) and go to CAND.
REQ-024 SCAN, no match and body_idx = body_len-1: commit candidate to apple_x/apple_y, assert apple_valid, tries = 0, go to PLACED.
REQ-025 SCAN, no match otherwise: body_idx+1.
REQ-026 body_len = 0: SCAN commits in its first cycle with no compare.
REQ-027 body_len > MAX_SEG is treated as MAX_SEG.
REQ-028 Latency from CAND entry to apple_valid for an accepted candidate: 1 + max(body_len,1) cycles.
REQ-029 PLACED: eaten -> apple_valid deasserts next cycle, go to CAND; apple_x/apple_y hold old values until next commit.
REQ-030 eaten in IDLE, CAND or SCAN is ignored and not queued.
REQ-031 Termination is guaranteed because MAX_SEG < GRID_W*GRID_H; the linear fallback reaches a free cell within GRID_W*GRID_H candidates.
REQ-032 body_idx is 0 outside SCAN.

Reset
REQ-033 reset high at a clock edge sets: state IDLE, apple_valid 0, apple_x 0, apple_y 0, body_idx 0, busy 0, tries 0, candidate (0,0).
REQ-034 reset mid-SCAN aborts the scan; no commit occurs in that cycle.
REQ-035 reset has priority over eaten.

Structure
REQ-036 The shared package snake_pkg holds GRID_W, GRID_H, MAX_SEG, a cell_t typedef (4-bit x, 4-bit y) and the FSM state enum.
REQ-037 Fold and linear-advance logic sit in one combinational sub-module, apple_cand_gen.
REQ-038 The top level holds the FSM, tries counter, scan index and output registers.

Verification
REQ-039 Reset, then release with body_len=4, body = {(4,7),(4,6),(4,5),(4,4)}, rand=(5,8) -> apple_valid rises 6 cycles after release, apple=(5,8).
REQ-040 Fold: rand=(15,14), body_len=1, body[0]=(0,0) -> apple=(1,0).
REQ-041 Collision retry: body[2]=(4,8), rand=(4,8) for the first candidate, then (9,9) -> tries reaches 1, apple=(9,9), no commit to (4,8).
REQ-042 Fallback: rand held at (4,7) (occupied) for 5 candidates, body has (5,7) -> after 4 rejected tries, linear candidates (5,7) rejected, then (6,7) committed.
REQ-043 Wrap: fallback from candidate (13,13) -> next candidate (0,0); from (13,2) -> (0,3).
REQ-044 eaten in PLACED -> apple_valid 0 next cycle, busy 1; a second eaten during SCAN is ignored; reset mid-SCAN -> all outputs at reset values next cycle.
